// File: rtl/istream_rx_pkg.sv
// -----------------------------------------------------------------------------
// istream_rx_pkg
// Shared constants and helpers for the istream receive buffer:
//   - ptr_width()     : pointer width (address bits plus one wrap bit)
//   - depth_is_pow2() : legality check for the FIFO depth
//   - STATS_CNT_W     : width of the optional statistics counters
// No ports (package).
// -----------------------------------------------------------------------------
package istream_rx_pkg;

    localparam int STATS_CNT_W = 32;

    // Pointer width: log2(depth) address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    // A legal depth is a power of two no smaller than two.
    function automatic bit depth_is_pow2(input int depth);
        return (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/istream_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// istream_rx_fifo_mem
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately not reset; the owner masks stale data.
// Ports:
//   istream_clk  in   clock
//   wr_en        in   write strobe
//   wr_addr      in   write address
//   wr_data      in   write data
//   rd_addr      in   read address
//   rd_data      out  read data (combinational from rd_addr)
// -----------------------------------------------------------------------------
module istream_rx_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  istream_clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge istream_clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/istream_rx_buffer.sv
// -----------------------------------------------------------------------------
// istream_rx_buffer
// DUT-side receiver for the istream protocol. Beats accepted on the upstream
// valid/ready port are stored in a DEPTH-entry FIFO and presented
// first-word-fall-through on the downstream ostream port.
//
// Optional feature macro: ISTREAM_RX_STATS_EN
//   When defined, adds saturating 32-bit counters istream_beat_cnt (accepted
//   pushes) and istream_stall_cnt (cycles with valid=1 and ready=0).
//
// Ports:
//   istream_clk         in   clock
//   istream_rst         in   synchronous active-high reset
//   istream_valid       in   upstream beat valid
//   istream_data        in   upstream beat data
//   istream_ready       out  buffer can accept a beat this cycle
//   istream_buff_full   out  FIFO holds DEPTH entries
//   istream_buff_empty  out  FIFO holds no entries
//   istream_buff_afull  out  occupancy >= AFULL_LVL
//   istream_level       out  current occupancy
//   istream_beat_cnt    out  accepted pushes (ISTREAM_RX_STATS_EN only)
//   istream_stall_cnt   out  stalled upstream cycles (ISTREAM_RX_STATS_EN only)
//   ostream_valid       out  downstream beat valid
//   ostream_data        out  head of FIFO, zero while empty
//   ostream_ready       in   downstream accepts the beat
// -----------------------------------------------------------------------------
module istream_rx_buffer
    import istream_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = DEPTH - 2
) (
    input  logic                         istream_clk,
    input  logic                         istream_rst,
    input  logic                         istream_valid,
    input  logic [DATA_WIDTH-1:0]        istream_data,
    output logic                         istream_ready,
    output logic                         istream_buff_full,
    output logic                         istream_buff_empty,
    output logic                         istream_buff_afull,
    output logic [$clog2(DEPTH):0]       istream_level,
`ifdef ISTREAM_RX_STATS_EN
    output logic [STATS_CNT_W-1:0]       istream_beat_cnt,
    output logic [STATS_CNT_W-1:0]       istream_stall_cnt,
`endif
    output logic                         ostream_valid,
    output logic [DATA_WIDTH-1:0]        ostream_data,
    input  logic                         ostream_ready
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] AFULL_V  = PTR_W'(AFULL_LVL);

    generate
        if (!depth_is_pow2(DEPTH)) begin : g_depth_chk
            $error("istream_rx_buffer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      level_r;
    logic                  ready_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  afull_r;

    logic                  push_s;
    logic                  pop_s;
    logic [PTR_W-1:0]      wr_ptr_nxt_s;
    logic [PTR_W-1:0]      rd_ptr_nxt_s;
    logic [PTR_W-1:0]      level_nxt_s;
    logic                  full_nxt_s;
    logic                  empty_nxt_s;
    logic                  afull_nxt_s;
    logic [DATA_WIDTH-1:0] mem_rd_data_s;

    // Handshakes and next-state pointer/flag computation.
    always_comb begin
        push_s = istream_valid && ready_r;
        pop_s  = !empty_r && ostream_ready;

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // Wrap bit disambiguates full from empty when the address bits match.
        level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
        full_nxt_s  = (wr_ptr_nxt_s[ADDR_W-1:0] == rd_ptr_nxt_s[ADDR_W-1:0]) &&
                      (wr_ptr_nxt_s[ADDR_W] != rd_ptr_nxt_s[ADDR_W]);
        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        afull_nxt_s = (level_nxt_s >= AFULL_V);
    end

    // Pointer and status registers. ready_r holds low through the reset
    // cycle and rises at the first non-reset edge, so upstream readiness
    // never depends combinationally on ostream_ready.
    always_ff @(posedge istream_clk) begin
        if (istream_rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= PTR_ZERO;
            ready_r  <= 1'b0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            ready_r  <= !full_nxt_s;
            full_r   <= full_nxt_s;
            empty_r  <= empty_nxt_s;
            afull_r  <= afull_nxt_s;
        end
    end

    istream_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .istream_clk (istream_clk),
        .wr_en       (push_s),
        .wr_addr     (wr_ptr_r[ADDR_W-1:0]),
        .wr_data     (istream_data),
        .rd_addr     (rd_ptr_r[ADDR_W-1:0]),
        .rd_data     (mem_rd_data_s)
    );

    // Head-of-FIFO data, masked to zero so stale memory never leaks out.
    always_comb begin
        if (empty_r) begin
            ostream_data = {DATA_WIDTH{1'b0}};
        end else begin
            ostream_data = mem_rd_data_s;
        end
    end

    assign istream_ready      = ready_r;
    assign istream_buff_full  = full_r;
    assign istream_buff_empty = empty_r;
    assign istream_buff_afull = afull_r;
    assign istream_level      = level_r;
    assign ostream_valid      = !empty_r;

`ifdef ISTREAM_RX_STATS_EN
    localparam logic [STATS_CNT_W-1:0] CNT_MAX = {STATS_CNT_W{1'b1}};
    localparam logic [STATS_CNT_W-1:0] CNT_ONE = {{(STATS_CNT_W-1){1'b0}}, 1'b1};

    logic [STATS_CNT_W-1:0] beat_cnt_r;
    logic [STATS_CNT_W-1:0] stall_cnt_r;

    // Saturating accepted-beat and stall counters.
    always_ff @(posedge istream_clk) begin
        if (istream_rst) begin
            beat_cnt_r  <= {STATS_CNT_W{1'b0}};
            stall_cnt_r <= {STATS_CNT_W{1'b0}};
        end else begin
            if (push_s && (beat_cnt_r != CNT_MAX)) begin
                beat_cnt_r <= beat_cnt_r + CNT_ONE;
            end
            if (istream_valid && !ready_r && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
        end
    end

    assign istream_beat_cnt  = beat_cnt_r;
    assign istream_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_istream_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_istream_rx_buffer
// Scoreboard bench for istream_rx_buffer with DEPTH=4, DATA_WIDTH=32.
// Accepted beats are pushed onto an expected-data queue; the head is compared
// against ostream_data every cycle and popped on each downstream handshake.
// Occupancy, flags and readiness come from the bench's own queue model.
// -----------------------------------------------------------------------------
module tb_istream_rx_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AFULL = 2;
    localparam int LW    = 3;

    logic          istream_clk = 1'b0;
    logic          istream_rst;
    logic          istream_valid;
    logic [DW-1:0] istream_data;
    logic          istream_ready;
    logic          istream_buff_full;
    logic          istream_buff_empty;
    logic          istream_buff_afull;
    logic [LW-1:0] istream_level;
    logic          ostream_valid;
    logic [DW-1:0] ostream_data;
    logic          ostream_ready;
`ifdef ISTREAM_RX_STATS_EN
    logic [31:0]   istream_beat_cnt;
    logic [31:0]   istream_stall_cnt;
`endif

    istream_rx_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .istream_clk        (istream_clk),
        .istream_rst        (istream_rst),
        .istream_valid      (istream_valid),
        .istream_data       (istream_data),
        .istream_ready      (istream_ready),
        .istream_buff_full  (istream_buff_full),
        .istream_buff_empty (istream_buff_empty),
        .istream_buff_afull (istream_buff_afull),
        .istream_level      (istream_level),
`ifdef ISTREAM_RX_STATS_EN
        .istream_beat_cnt   (istream_beat_cnt),
        .istream_stall_cnt  (istream_stall_cnt),
`endif
        .ostream_valid      (ostream_valid),
        .ostream_data       (ostream_data),
        .ostream_ready      (ostream_ready)
    );

    always #5 istream_clk = ~istream_clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    bit            m_rdy;
    int unsigned   m_beat;
    int unsigned   m_stall;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs at the falling edge against the
    // model, then advance the model across the rising edge.
    task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input bit ordy);
        int sz;
        bit push;
        bit pop;
        istream_rst   = r;
        istream_valid = v;
        istream_data  = d;
        ostream_ready = ordy;
        @(negedge istream_clk);
        sz = exp_q.size();
        chk_val("ready",  istream_ready,      m_rdy);
        chk_val("empty",  istream_buff_empty, sz == 0);
        chk_val("full",   istream_buff_full,  sz == DEPTH);
        chk_val("afull",  istream_buff_afull, sz >= AFULL);
        chk_val("level",  istream_level,      sz);
        chk_val("ovalid", ostream_valid,      sz != 0);
        if (sz == 0) begin
            chk_val("odata_empty", ostream_data, 64'h0);
        end else begin
            chk_val("odata", ostream_data, exp_q[0]);
        end
`ifdef ISTREAM_RX_STATS_EN
        chk_val("beat_cnt",  istream_beat_cnt,  m_beat);
        chk_val("stall_cnt", istream_stall_cnt, m_stall);
`endif
        @(posedge istream_clk);
        #1;
        if (r) begin
            exp_q.delete();
            m_rdy   = 1'b0;
            m_beat  = 0;
            m_stall = 0;
        end else begin
            pop  = (sz != 0) && ordy;
            push = v && m_rdy;
            if (v && !m_rdy) m_stall++;
            if (push) m_beat++;
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(d);
            m_rdy = (exp_q.size() != DEPTH);
        end
    endtask

    initial begin
        m_rdy   = 1'b0;
        m_beat  = 0;
        m_stall = 0;
        istream_rst   = 1'b1;
        istream_valid = 1'b1;
        istream_data  = 32'h55;
        ostream_ready = 1'b0;
        @(posedge istream_clk);
        #1;

        // Reset held a second cycle with valid high, then released.
        step(1'b1, 1'b1, 32'h55, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b0);

        // Fill to full; a fifth beat is held off.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'hA4, 1'b0);

        // Drain in order; A4 is accepted once space opens.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'hA4, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0,  1'b1);

        // Streaming with both sides always ready, crossing the wrap repeatedly.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 32'h100 + 32'(i), 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Full with simultaneous pop: pop only, then the held push lands.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hB0 + 32'(i), 1'b0);
        step(1'b0, 1'b1, 32'hB4, 1'b1);
        step(1'b0, 1'b1, 32'hB4, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b0);

        // Reset mid-operation at level 3.
        step(1'b0, 1'b0, 32'h0,  1'b1);
        step(1'b1, 1'b0, 32'h0,  1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b0);
        step(1'b0, 1'b1, 32'hC0, 1'b1);
        step(1'b0, 1'b0, 32'h0,  1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b1);
        step(1'b0, 1'b0, 32'h0,  1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
